// File: rtl/key_scan_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad scanner.
// A matrix bit index is row*KS_COLS+col, with 1 meaning the key is down.
package key_scan_pkg;

  localparam int KS_ROWS   = 4;
  localparam int KS_COLS   = 4;
  localparam int KS_CODE_W = 4;
  localparam int KS_KEYS   = KS_ROWS * KS_COLS;

  localparam logic [KS_COLS-1:0] KS_COL_RESET = 4'b1110;

  typedef logic [KS_KEYS-1:0] ks_matrix_t;

  function automatic logic ks_is_single(input ks_matrix_t m);
    int n;
    n = 0;
    for (int i = 0; i < KS_KEYS; i++) n = n + int'(m[i]);
    return (n == 1);
  endfunction

  function automatic logic [KS_CODE_W-1:0] ks_code(input ks_matrix_t m);
    logic [KS_CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < KS_KEYS; i++) begin
      if (m[i]) code = KS_CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_scan_if.sv
// Keypad matrix and key-event bundle between the scanner (master) and
// the panel / control logic (slave).
interface key_scan_if;
  import key_scan_pkg::*;

  logic [KS_ROWS-1:0]   row_n;
  logic [KS_COLS-1:0]   col_n;
  logic [KS_CODE_W-1:0] key_code;
  logic                 key_valid;
  logic                 key_release;
  logic                 key_held;

  modport master (
    input  row_n,
    output col_n, key_code, key_valid, key_release, key_held
  );

  modport slave (
    output row_n,
    input  col_n, key_code, key_valid, key_release, key_held
  );
endinterface

// File: rtl/key_scan_sync_2ff.sv
// Two-flop synchronizer; resets to all-ones because the synchronized
// inputs are active-low and idle high.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: rotates an active-low column, snapshots the rows
// into a full-matrix frame, debounces whole frames and emits press/release events.
module key_scan
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  key_scan_if.master kif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int COL_W = $clog2(KS_COLS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(KS_COLS - 1);

  logic [KS_ROWS-1:0]   w_rows_n;
  logic [DIV_W-1:0]     r_div;
  logic [COL_W-1:0]     r_col;
  logic [KS_COLS-1:0]   r_col_n;
  ks_matrix_t           r_snap;
  ks_matrix_t           r_prev;
  ks_matrix_t           r_deb;
  ks_matrix_t           w_deb_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 r_frame_p1;
  logic                 w_tick;
  logic                 w_press;
  logic                 w_release;
  logic                 r_valid;
  logic                 r_release;
  logic                 r_held;
  logic [KS_CODE_W-1:0] r_code;

  sync_2ff #(.WIDTH(KS_ROWS)) u_row_sync (
    .clk (clk),
    .rst (reset_n),
    .i_d (kif.row_n),
    .o_q (w_rows_n)
  );

  assign w_tick = (r_div == DIV_LAST);

  // Stage 0: column drive and per-column row capture into the frame snapshot
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_div      <= '0;
      r_col      <= '0;
      r_col_n    <= KS_COL_RESET;
      r_snap     <= '0;
      r_frame_p1 <= 1'b0;
    end else begin
      r_frame_p1 <= w_tick && (r_col == COL_LAST);
      if (w_tick) begin
        r_div   <= '0;
        r_col   <= r_col + 1'b1;
        r_col_n <= {r_col_n[KS_COLS-2:0], r_col_n[KS_COLS-1]};
        for (int r = 0; r < KS_ROWS; r++) begin
          r_snap[r*KS_COLS + int'(r_col)] <= ~w_rows_n[r];
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_deb_nxt = r_deb;
    if (r_frame_p1) begin
      if (r_snap == r_prev) begin
        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      end else begin
        w_cnt_nxt = CNT_W'(1);
      end
      if (w_cnt_nxt == CNT_MAX) w_deb_nxt = r_snap;
    end
  end

  // A press needs an all-released prior state, which also rejects multi->single.
  assign w_press   = (r_deb == '0) && ks_is_single(w_deb_nxt);
  assign w_release = (r_deb != '0) && (w_deb_nxt == '0);

  // Stage 1: frame evaluation, debounced state and registered events
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_prev    <= '0;
      r_cnt     <= '0;
      r_deb     <= '0;
      r_valid   <= 1'b0;
      r_release <= 1'b0;
      r_held    <= 1'b0;
      r_code    <= '0;
    end else begin
      if (r_frame_p1) r_prev <= r_snap;
      r_cnt     <= w_cnt_nxt;
      r_deb     <= w_deb_nxt;
      r_valid   <= w_press;
      r_release <= w_release;
      r_held    <= (w_deb_nxt != '0);
      if (w_press) r_code <= ks_code(w_deb_nxt);
    end
  end

  assign kif.col_n       = r_col_n;
  assign kif.key_code    = r_code;
  assign kif.key_valid   = r_valid;
  assign kif.key_release = r_release;
  assign kif.key_held    = r_held;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with SCAN_DIV=4, DEBOUNCE_FRAMES=3 and a
// behavioural 4x4 matrix driving the rows from the scanned columns.
module tb_key_scan;
  import key_scan_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pressed;
  logic [3:0]  w_rows;
  int n_vec = 0;
  int n_err = 0;
  int n_valid, n_rel, n_both, n_held;

  key_scan_if kif ();

  key_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kif     (kif)
  );

  always #5 clk = ~clk;

  always_comb begin
    w_rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (kif.col_n[c] == 1'b0)) w_rows[r] = 1'b0;
  end
  assign kif.row_n = w_rows;

  task automatic clear_counts();
    n_valid = 0; n_rel = 0; n_both = 0; n_held = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (kif.key_valid === 1'b1) n_valid++;
    if (kif.key_release === 1'b1) n_rel++;
    if (kif.key_valid === 1'b1 && kif.key_release === 1'b1) n_both++;
    if (kif.key_held === 1'b1) n_held++;
  endtask

  task automatic test_reset();
    logic [3:0] exp_cols [4];
    exp_cols[0] = 4'b1101; exp_cols[1] = 4'b1011;
    exp_cols[2] = 4'b0111; exp_cols[3] = 4'b1110;
    pressed = '0;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++; if (kif.col_n !== 4'b1110) begin n_err++; $display("FAIL rst_col_n got %b want 1110", kif.col_n); end
    n_vec++; if (kif.key_code !== 4'd0) begin n_err++; $display("FAIL rst_key_code got %0d want 0", kif.key_code); end
    n_vec++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL rst_key_valid got %b want 0", kif.key_valid); end
    n_vec++; if (kif.key_release !== 1'b0) begin n_err++; $display("FAIL rst_key_release got %b want 0", kif.key_release); end
    n_vec++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL rst_key_held got %b want 0", kif.key_held); end
    reset_n = 1'b0;
    clear_counts();
    repeat (3) tick();
    n_vec++; if (kif.col_n !== 4'b1110) begin n_err++; $display("FAIL scan_hold_c0 got %b want 1110", kif.col_n); end
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (4) tick();
      n_vec++;
      if (kif.col_n !== exp_cols[i]) begin
        n_err++; $display("FAIL scan_rotate_%0d got %b want %b", i, kif.col_n, exp_cols[i]);
      end
    end
  endtask

  task automatic test_press();
    bit seen;
    clear_counts();
    pressed = 16'h0001 << 9;
    seen = 0;
    for (int i = 0; i < 84; i++) begin
      tick();
      if (kif.key_valid === 1'b1 && !seen) begin
        seen = 1;
        n_vec++; if (kif.key_code !== 4'd9) begin n_err++; $display("FAIL press_code got %0d want 9", kif.key_code); end
        n_vec++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL press_held got %b want 1", kif.key_held); end
      end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL press_latency got none want pulse within 84"); end
    repeat (116) tick();
    n_vec++; if (n_valid != 1) begin n_err++; $display("FAIL press_count got %0d want 1", n_valid); end
    clear_counts();
    pressed = '0;
    seen = 0;
    for (int i = 0; i < 84; i++) begin
      tick();
      if (kif.key_release === 1'b1) seen = 1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL release_latency got none want pulse within 84"); end
    repeat (36) tick();
    n_vec++; if (n_rel != 1) begin n_err++; $display("FAIL release_count got %0d want 1", n_rel); end
    n_vec++; if (n_valid != 0) begin n_err++; $display("FAIL release_no_valid got %0d want 0", n_valid); end
    n_vec++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL release_held got %b want 0", kif.key_held); end
    n_vec++; if (kif.key_code !== 4'd9) begin n_err++; $display("FAIL release_code got %0d want 9", kif.key_code); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 32 && kif.col_n !== 4'b0111; i++) tick();
    n_vec++; if (kif.col_n !== 4'b0111) begin n_err++; $display("FAIL bounce_align got %b want 0111", kif.col_n); end
    tick();
    clear_counts();
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      repeat (10) tick();
    end
    pressed = '0;
    repeat (80) tick();
    n_vec++; if (n_valid != 0) begin n_err++; $display("FAIL bounce_valid got %0d want 0", n_valid); end
    n_vec++; if (n_rel != 0) begin n_err++; $display("FAIL bounce_release got %0d want 0", n_rel); end
    n_vec++; if (n_held != 0) begin n_err++; $display("FAIL bounce_held got %0d cycles want 0", n_held); end
  endtask

  task automatic test_ghost();
    clear_counts();
    pressed = 16'h8001;
    repeat (200) tick();
    n_vec++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL ghost_held got %b want 1", kif.key_held); end
    n_vec++; if (n_valid != 0) begin n_err++; $display("FAIL ghost_valid got %0d want 0", n_valid); end
    pressed = 16'h8000;
    repeat (200) tick();
    n_vec++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL multi_single_held got %b want 1", kif.key_held); end
    n_vec++; if (n_valid != 0) begin n_err++; $display("FAIL multi_single_valid got %0d want 0", n_valid); end
    n_vec++; if (n_rel != 0) begin n_err++; $display("FAIL multi_single_release got %0d want 0", n_rel); end
    pressed = '0;
    repeat (120) tick();
    n_vec++; if (n_rel != 1) begin n_err++; $display("FAIL ghost_release got %0d want 1", n_rel); end
    n_vec++; if (kif.key_code !== 4'd9) begin n_err++; $display("FAIL ghost_code got %0d want 9", kif.key_code); end
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    clear_counts();
    pressed = 16'h0001 << 5;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (n_valid > 0 && kif.key_code !== 4'd5) bad++;
    end
    n_vec++; if (n_valid != 1) begin n_err++; $display("FAIL hold_valid_count got %0d want 1", n_valid); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL hold_code got %0d bad cycles want 0", bad); end
    n_vec++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL hold_held got %b want 1", kif.key_held); end
    n_vec++; if (n_both != 0) begin n_err++; $display("FAIL hold_overlap got %0d want 0", n_both); end
    pressed = '0;
    repeat (120) tick();
    n_vec++; if (n_rel != 1) begin n_err++; $display("FAIL hold_release got %0d want 1", n_rel); end
  endtask

  task automatic test_reset_mid();
    int first;
    for (int i = 0; i < 32 && kif.col_n !== 4'b1101; i++) tick();
    n_vec++; if (kif.col_n !== 4'b1101) begin n_err++; $display("FAIL mid_align got %b want 1101", kif.col_n); end
    clear_counts();
    pressed = 16'h0001 << 12;
    repeat (40) tick();
    n_vec++; if (n_valid != 0) begin n_err++; $display("FAIL mid_early_valid got %0d want 0", n_valid); end
    reset_n = 1'b1;
    tick();
    n_vec++; if (kif.col_n !== 4'b1110) begin n_err++; $display("FAIL mid_rst_col_n got %b want 1110", kif.col_n); end
    n_vec++; if (kif.key_code !== 4'd0) begin n_err++; $display("FAIL mid_rst_code got %0d want 0", kif.key_code); end
    n_vec++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", kif.key_valid); end
    n_vec++; if (kif.key_release !== 1'b0) begin n_err++; $display("FAIL mid_rst_release got %b want 0", kif.key_release); end
    n_vec++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL mid_rst_held got %b want 0", kif.key_held); end
    reset_n = 1'b0;
    clear_counts();
    first = -1;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (kif.key_valid === 1'b1 && first < 0) begin
        first = k;
        n_vec++; if (kif.key_code !== 4'd12) begin n_err++; $display("FAIL mid_code got %0d want 12", kif.key_code); end
      end
    end
    n_vec++;
    if (first < 48 || first > 84) begin
      n_err++; $display("FAIL mid_latency got %0d want 48..84 cycles", first);
    end
    n_vec++; if (n_valid != 1) begin n_err++; $display("FAIL mid_valid_count got %0d want 1", n_valid); end
    pressed = '0;
    repeat (120) tick();
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_ghost();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
4x4 matrix keypad scanner for the digital clock front panel. It is the input-side counterpart of the LED scan display: it drives one active-low column at a time and reads back active-low rows. It debounces whole-matrix snapshots and emits a one-cycle press event with a 4-bit key code. It also emits a release event. Consumers are the clock-setting / mode control logic.

Parameters:
SCAN_DIV, 5000, clk cycles each column stays active; must be >= 4.
DEBOUNCE_FRAMES, 8, consecutive identical full-matrix frames required before the debounced state updates; must be >= 1.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-high (asserted when 1), despite the codebase name
row_n  in  4  matrix rows; asynchronous, active-low, externally pulled up
col_n  out  4  column drive; active-low one-hot
key_code  out  4  code of last valid press, row*4+col
key_valid  out  1  one-cycle pulse on a qualified press
key_release  out  1  one-cycle pulse when the matrix returns to no keys
key_held  out  1  high while the debounced state has any key down

Behaviour:
- Reset values: col_n=4'b1110, key_code=0, key_valid=0, key_release=0, key_held=0. Also cleared by reset:
  - divider, column index, snapshot, debounced state, stable counter.
- Reset mid-operation discards any in-progress frame or debounce. No event may be emitted from pre-reset samples.
- row_n passes through a 2-FF synchronizer before any use.
- Column scan:
  - A divider counts 0..SCAN_DIV-1.
  - When the divider is at SCAN_DIV-1, the synchronized rows are sampled into snapshot bits for the current column c (bit = row*4+c, 1 = pressed).
  - In that same cycle, c advances to (c+1) mod 4 and col_n rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Frame: one frame completes when column 3 is sampled, i.e. every 4*SCAN_DIV cycles. The evaluation happens on the cycle after the column-3 sample.
- Debounce, on each completed frame:
  - If snapshot == previous frame's snapshot: stable count increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise: stable count resets to 1.
  - When the count reaches DEBOUNCE_FRAMES and snapshot != debounced, debounced <= snapshot.
- Events are evaluated on the cycle the debounced state changes, old -> new. Outputs are registered and visible on the following cycle.
  - Press (old==0 and new has exactly one bit set): key_valid=1 for one cycle; key_code <= index of that bit.
  - Release (old!=0 and new==0): key_release=1 for one cycle; key_code holds its value.
  - Ghost/multi-key:
    - A transition into a state with two or more bits produces no key_valid.
    - A multi-key -> single-key transition produces no key_valid; a press always requires a prior all-released state.
  - key_held = (debounced != 0).
- No auto-repeat: a held key yields exactly one key_valid.
- key_valid and key_release are never high in the same cycle.
- Worst-case press latency from a stable input to key_valid is (DEBOUNCE_FRAMES+2)*4*SCAN_DIV+4 cycles.

Decomposition:
- Package key_scan_pkg holds:
  - KS_ROWS=4, KS_COLS=4, KS_CODE_W=4
  - KS_COL_RESET=4'b1110
  - a function for one-hot-to-code / popcount==1 check
- One sub-module: sync_2ff (parameterised width, reset to 1s since inputs are active-low idle-high), instantiated for row_n.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=3. The bench matrix model is row_n[r] = ~(pressed[r][c] & ~col_n[c]), OR-ed over c.

1. Reset held 5 cycles, then released -> col_n=1110, key_code=0, all pulses 0. col_n then reads 1101 at +4 cycles, 1011 at +8, 0111 at +12, 1110 at +16.
2. Press row2/col1, hold 200 cycles, then release -> press side:
   - exactly one key_valid pulse, with key_code=9 and key_held=1, within 84 cycles of press
   Release side:
   - after release, exactly one key_release pulse within 84 cycles
   - key_held=0, key_code stays 9
3. Bounce: toggle row0/col3 every 10 cycles for 60 cycles, then leave released -> zero key_valid, zero key_release, key_held never 1.
4. Press codes 0 and 15 together for 200 cycles -> key_held=1, no key_valid. Release code 0 only, keeping 15 for 200 cycles -> still no key_valid. Release all -> one key_release.
5. Hold code 5 for 1000 cycles -> exactly one key_valid. key_code=5 throughout after the pulse.
6. Press code 12, assert reset_n for 1 cycle at cycle 40 (mid-debounce), keep the key pressed -> outputs:
   - all outputs return to reset values
   - exactly one key_valid with key_code=12, occurring at least 3 full frames (48 cycles) after reset deasserts
